// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM user-port arbiter.
//   arb_state_e   : transaction phase of the arbiter (IDLE, ISSUE, WAIT, DONE)
//   CTRL_*        : encoding of the 3-bit access control field forwarded to the
//                   memory controller ([1:0] size, [2] zero-extend)
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] CTRL_B        = 2'd0;
  localparam logic [1:0] CTRL_H        = 2'd1;
  localparam logic [1:0] CTRL_W        = 2'd2;
  localparam int         CTRL_UNSIGNED = 2;

endpackage

// File: rtl/dram_port_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts; the search wraps past NREQ-1
//   grant : one-hot winner (all zero when nothing requests)
//   idx   : binary index of the winner
//   any   : at least one request is present
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int   k;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = PW'(k);
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing the single DRAM_conRV user port among NREQ
// requesters. One transaction at a time: the winner's request is latched in
// IDLE, the enable is held until the memory reports busy, completion is seen
// when busy falls, and a one-cycle ack returns the read data.
//   clk, rst_x              : clock, asynchronous active-low reset
//   s_req/s_we/s_addr/
//   s_wdata/s_ctrl          : per-requester level request and its payload
//   s_ack, s_rdata          : one-hot completion pulse and returned data
//   m_rd_en/m_wr_en/m_addr/
//   m_wdata/m_ctrl          : registered command to the memory controller
//   m_rdata, m_busy         : data and busy status from the memory controller
//   o_grant                 : one-hot owner of the transaction in flight
//   o_timeout               : sticky watchdog flag
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                 clk,
  input  logic                 rst_x,
  input  logic [NREQ-1:0]      s_req,
  input  logic [NREQ-1:0]      s_we,
  input  logic [NREQ*32-1:0]   s_addr,
  input  logic [NREQ*32-1:0]   s_wdata,
  input  logic [NREQ*3-1:0]    s_ctrl,
  output logic [NREQ-1:0]      s_ack,
  output logic [31:0]          s_rdata,
  output logic                 m_rd_en,
  output logic                 m_wr_en,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  output logic [2:0]           m_ctrl,
  input  logic [31:0]          m_rdata,
  input  logic                 m_busy,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  arb_state_e      state;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] win_grant;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic [CW-1:0]   wd_cnt;
  logic [CW-1:0]   wd_next;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (s_req),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Watchdog count saturates at the limit so the flag cannot wrap away.
  function automatic logic [CW-1:0] wd_inc(input logic [CW-1:0] c);
    return (c == TO_LIMIT) ? c : c + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    if (int'(w) == NREQ - 1) return '0;
    return w + 1'b1;
  endfunction

  assign wd_next = wd_inc(wd_cnt);

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state     <= IDLE;
      ptr       <= '0;
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
      o_grant   <= '0;
      s_ack     <= '0;
      s_rdata   <= '0;
      m_rd_en   <= 1'b0;
      m_wr_en   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_ctrl    <= '0;
    end else begin
      s_ack <= '0;
      unique case (state)
        // Requester inputs are only looked at here; later phases use the copy.
        IDLE: begin
          if (win_any) begin
            m_addr  <= s_addr[32*int'(win_idx) +: 32];
            m_wdata <= s_wdata[32*int'(win_idx) +: 32];
            m_ctrl  <= s_ctrl[3*int'(win_idx) +: 3];
            m_rd_en <= ~s_we[win_idx];
            m_wr_en <= s_we[win_idx];
            o_grant <= win_grant;
            ptr     <= ptr_after(win_idx);
            state   <= ISSUE;
          end
        end
        // Enable stays up until busy is seen; the controller ignores it while
        // refreshing, so lingering high cycles cannot start a second access.
        ISSUE: begin
          wd_cnt <= wd_next;
          if (wd_next == TO_LIMIT) o_timeout <= 1'b1;
          if (m_busy) begin
            m_rd_en <= 1'b0;
            m_wr_en <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (wd_next == TO_LIMIT) o_timeout <= 1'b1;
          if (!m_busy) begin
            s_rdata <= m_rdata;
            s_ack   <= o_grant;
            wd_cnt  <= '0;
            state   <= DONE;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        DONE: begin
          o_grant <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
